// File: rtl/panic_credit_scheduler_if.sv
// panic_credit_scheduler_if
// Descriptor-in / grant-out bundle of the panic credit scheduler.
//   s_desc_*  : descriptor from the ingress parser (valid, ready, engine mask, tag)
//   m_grant_* : grant to the compute engines (valid, ready, engine index, tag)
// Modports:
//   slave  : scheduler side (consumes descriptors, produces grants)
//   master : environment side (produces descriptors, consumes grants)
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1; the sender holds payload stable while valid & !ready.
interface panic_credit_scheduler_if #(
  parameter int ENGINE_NUM   = 4,
  parameter int TAG_WIDTH    = 8,
  parameter int ENG_ID_WIDTH = 2
);
  logic                    s_desc_valid;
  logic                    s_desc_ready;
  logic [ENGINE_NUM-1:0]   s_desc_mask;
  logic [TAG_WIDTH-1:0]    s_desc_tag;
  logic                    m_grant_valid;
  logic                    m_grant_ready;
  logic [ENG_ID_WIDTH-1:0] m_grant_engine;
  logic [TAG_WIDTH-1:0]    m_grant_tag;

  modport slave (
    input  s_desc_valid, s_desc_mask, s_desc_tag, m_grant_ready,
    output s_desc_ready, m_grant_valid, m_grant_engine, m_grant_tag
  );

  modport master (
    output s_desc_valid, s_desc_mask, s_desc_tag, m_grant_ready,
    input  s_desc_ready, m_grant_valid, m_grant_engine, m_grant_tag
  );
endinterface

// File: rtl/panic_credit_scheduler.sv
// panic_credit_scheduler
// Credit-based round-robin dispatcher of packet descriptors to compute engines.
// A descriptor is granted to the first engine, in round-robin order starting at
// the pointer, that is in its mask and still holds credit. Credits come back via
// credit_return pulses; a return to an already-full engine saturates and sets
// the sticky credit_err flag.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 0 blocks acceptance of new descriptors
//   bus (slave)   : descriptor input and grant output handshakes
//   credit_return : per-engine one-credit return pulses
//   credit_count  : registered credits, engine i at [i*CREDIT_WIDTH +: CREDIT_WIDTH]
//   credit_err    : sticky over-return flag
module panic_credit_scheduler #(
  parameter int ENGINE_NUM      = 4,
  parameter int INIT_CREDIT_NUM = 2,
  parameter int CREDIT_WIDTH    = 4,
  parameter int TAG_WIDTH       = 8,
  parameter int ENG_ID_WIDTH    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  panic_credit_scheduler_if.slave            bus,
  input  logic [ENGINE_NUM-1:0]              credit_return,
  output logic [ENGINE_NUM*CREDIT_WIDTH-1:0] credit_count,
  output logic                               credit_err
);
  localparam logic [CREDIT_WIDTH-1:0]   CREDIT_MAX = CREDIT_WIDTH'(INIT_CREDIT_NUM);
  localparam logic [ENG_ID_WIDTH:0]     ENG_NUM_W  = (ENG_ID_WIDTH+1)'(ENGINE_NUM);
  localparam logic [ENG_ID_WIDTH-1:0]   LAST_ENG   = ENG_ID_WIDTH'(ENGINE_NUM-1);

  logic [CREDIT_WIDTH-1:0] credit_q [ENGINE_NUM];
  logic [CREDIT_WIDTH-1:0] credit_d [ENGINE_NUM];
  logic [ENG_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [ENG_ID_WIDTH-1:0] grant_engine_q, grant_engine_d;
  logic [TAG_WIDTH-1:0]    grant_tag_q, grant_tag_d;
  logic                    err_q, err_d;

  logic [ENGINE_NUM-1:0]   eligible;
  logic [ENG_ID_WIDTH-1:0] sel;
  logic                    found;
  logic                    accept;
  logic [ENG_ID_WIDTH:0]   idx_w;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      eligible[i] = bus.s_desc_mask[i] & (credit_q[i] != '0);
    end
  end

  // Rotating priority search: ptr, ptr+1, ... wrapping at ENGINE_NUM.
  // ptr+k stays below 2*ENGINE_NUM, so a single conditional subtract wraps it.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx_w = '0;
    for (int k = 0; k < ENGINE_NUM; k++) begin
      idx_w = {1'b0, ptr_q} + (ENG_ID_WIDTH+1)'(k);
      if (idx_w >= ENG_NUM_W) idx_w = idx_w - ENG_NUM_W;
      if (!found && eligible[idx_w[ENG_ID_WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = idx_w[ENG_ID_WIDTH-1:0];
      end
    end
  end

  // A new descriptor is taken only if the grant register is free or being
  // drained this cycle, so grants never overwrite an unconsumed one.
  assign bus.s_desc_ready = enable & (~grant_valid_q | bus.m_grant_ready) & found;
  assign accept           = bus.s_desc_valid & bus.s_desc_ready;

  always_comb begin
    grant_valid_d  = grant_valid_q;
    grant_engine_d = grant_engine_q;
    grant_tag_d    = grant_tag_q;
    ptr_d          = ptr_q;
    err_d          = err_q;
    for (int i = 0; i < ENGINE_NUM; i++) credit_d[i] = credit_q[i];

    if (accept) begin
      grant_valid_d  = 1'b1;
      grant_engine_d = sel;
      grant_tag_d    = bus.s_desc_tag;
      ptr_d          = (sel == LAST_ENG) ? '0 : sel + 1'b1;
    end else if (bus.m_grant_ready) begin
      grant_valid_d  = 1'b0;
    end

    // Dispatch and return to the same engine in one cycle cancel out, so a
    // return to a full engine is only an error without a same-cycle dispatch.
    for (int i = 0; i < ENGINE_NUM; i++) begin
      if (accept && (sel == ENG_ID_WIDTH'(i))) begin
        if (!credit_return[i]) credit_d[i] = credit_q[i] - 1'b1;
      end else if (credit_return[i]) begin
        if (credit_q[i] == CREDIT_MAX) err_d = 1'b1;
        else                           credit_d[i] = credit_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENGINE_NUM; i++) credit_q[i] <= CREDIT_MAX;
      ptr_q          <= '0;
      grant_valid_q  <= 1'b0;
      grant_engine_q <= '0;
      grant_tag_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      for (int i = 0; i < ENGINE_NUM; i++) credit_q[i] <= credit_d[i];
      ptr_q          <= ptr_d;
      grant_valid_q  <= grant_valid_d;
      grant_engine_q <= grant_engine_d;
      grant_tag_q    <= grant_tag_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    credit_count = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      credit_count[i*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[i];
    end
  end

  assign bus.m_grant_valid  = grant_valid_q;
  assign bus.m_grant_engine = grant_engine_q;
  assign bus.m_grant_tag    = grant_tag_q;
  assign credit_err         = err_q;
endmodule
